// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore main control FSM for a multicycle MIPS datapath with optional memory timeout.
// Define MIPS_ILLEGAL_TRAP_EN to trap unsupported opcodes instead of treating them as NOPs.
module mips_multicycle_control #(
  parameter int STATE_W = 4,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Opcode,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               instr_done,
  output logic               mem_err,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB,
    BRANCH, JUMP, ADDI_EX, ADDI_WB, TRAP
  } state_t;
`ifdef MIPS_ILLEGAL_TRAP_EN
  localparam state_t ILL_ST = TRAP;
`else
  localparam state_t ILL_ST = FETCH;
`endif
  localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  state_t cur, nxt;
  logic [CW-1:0] wcnt;
  logic wait_st, tmo, unused;
  assign unused = Zero;
  assign wait_st = cur == FETCH || cur == MEMRD || cur == MEMWR;
  assign tmo = MEM_TIMEOUT != 0 && rst_n && wait_st && !mem_ready && wcnt == CW'(MEM_TIMEOUT - 1);
  assign mem_err = tmo;
  assign state = STATE_W'(cur);
`ifdef MIPS_ILLEGAL_TRAP_EN
  assign illegal_op = cur == TRAP;
`else
  assign illegal_op = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur  <= FETCH;
      wcnt <= '0;
    end else begin
      cur  <= nxt;
      wcnt <= (nxt != cur || tmo) ? '0 :
              (MEM_TIMEOUT != 0 && wait_st && !mem_ready) ? wcnt + 1'b1 : wcnt;
    end
  end
  always_comb begin
    nxt = cur;
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    MemtoReg = 1'b0;
    RegDst = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    ALUOp = 2'b00;
    PCSource = 2'b00;
    instr_done = 1'b0;
    case (cur)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // gated by rst_n so nothing is written while reset is held
        IRWrite = mem_ready & rst_n;
        PCWrite = mem_ready & rst_n;
        nxt = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        nxt = Opcode == 6'h00 ? EXEC :
              (Opcode == 6'h23 || Opcode == 6'h2b) ? MEMADR :
              Opcode == 6'h04 ? BRANCH :
              Opcode == 6'h02 ? JUMP :
              Opcode == 6'h08 ? ADDI_EX : ILL_ST;
        instr_done = nxt == FETCH;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt = Opcode == 6'h23 ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        nxt = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        instr_done = 1'b1;
        nxt = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
        instr_done = mem_ready;
        nxt = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b10;
        nxt = RWB;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst = 1'b1;
        instr_done = 1'b1;
        nxt = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b01;
        PCWriteCond = 1'b1;
        PCSource = 2'b01;
        instr_done = 1'b1;
        nxt = FETCH;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSource = 2'b10;
        instr_done = 1'b1;
        nxt = FETCH;
      end
      ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt = ADDI_WB;
      end
      ADDI_WB: begin
        RegWrite = 1'b1;
        instr_done = 1'b1;
        nxt = FETCH;
      end
`ifdef MIPS_ILLEGAL_TRAP_EN
      TRAP: nxt = TRAP;
`endif
      default: nxt = FETCH;
    endcase
    if (tmo) nxt = FETCH;
  end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed and random checks of the multicycle control FSM against a path/table model.
// u0 waits forever on memory, u1 aborts after two idle cycles.
module tb_mips_multicycle_control;
  logic clk = 1'b0, rst_n = 1'b0, Zero = 1'b0, mem_ready = 1'b0, sel = 1'b0;
  logic [5:0] Opcode = 6'h00;
  wire [16:0] c0, c1;
  wire [3:0] s0, s1;
  wire e0, e1, i0, i1;
  int total = 0, bad = 0;
  int path[$];
`ifdef MIPS_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  always #5 clk = ~clk;
  mips_multicycle_control u0 (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(c0[16]), .PCWriteCond(c0[15]), .IorD(c0[14]), .MemRead(c0[13]), .MemWrite(c0[12]),
    .IRWrite(c0[11]), .MemtoReg(c0[10]), .RegDst(c0[9]), .RegWrite(c0[8]), .ALUSrcA(c0[7]),
    .ALUSrcB(c0[6:5]), .ALUOp(c0[4:3]), .PCSource(c0[2:1]), .instr_done(c0[0]),
    .mem_err(e0), .illegal_op(i0), .state(s0));
  mips_multicycle_control #(.MEM_TIMEOUT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(c1[16]), .PCWriteCond(c1[15]), .IorD(c1[14]), .MemRead(c1[13]), .MemWrite(c1[12]),
    .IRWrite(c1[11]), .MemtoReg(c1[10]), .RegDst(c1[9]), .RegWrite(c1[8]), .ALUSrcA(c1[7]),
    .ALUSrcB(c1[6:5]), .ALUOp(c1[4:3]), .PCSource(c1[2:1]), .instr_done(c1[0]),
    .mem_err(e1), .illegal_op(i1), .state(s1));
  wire [16:0] ctl = sel ? c1 : c0;
  wire [3:0] st = sel ? s1 : s0;
  wire err = sel ? e1 : e0;
  wire ill = sel ? i1 : i0;
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,instr_done}
  function automatic logic [16:0] exp_ctl(int s, logic mr, logic nop);
    logic [16:0] v;
    v = '0;
    case (s)
      0: begin v[13] = 1'b1; v[6:5] = 2'b01; v[16] = mr; v[11] = mr; end
      1: begin v[6:5] = 2'b11; v[0] = nop; end
      2: begin v[7] = 1'b1; v[6:5] = 2'b10; end
      3: begin v[14] = 1'b1; v[13] = 1'b1; end
      4: begin v[8] = 1'b1; v[10] = 1'b1; v[0] = 1'b1; end
      5: begin v[12] = 1'b1; v[14] = 1'b1; v[0] = mr; end
      6: begin v[7] = 1'b1; v[4:3] = 2'b10; end
      7: begin v[8] = 1'b1; v[9] = 1'b1; v[0] = 1'b1; end
      8: begin v[7] = 1'b1; v[4:3] = 2'b01; v[15] = 1'b1; v[2:1] = 2'b01; v[0] = 1'b1; end
      9: begin v[16] = 1'b1; v[2:1] = 2'b10; v[0] = 1'b1; end
      10: begin v[7] = 1'b1; v[6:5] = 2'b10; end
      11: begin v[8] = 1'b1; v[0] = 1'b1; end
      default: ;
    endcase
    return v;
  endfunction
  task automatic build_path(input logic [5:0] op);
    case (op)
      6'h23: path = {0, 1, 2, 3, 4};
      6'h2b: path = {0, 1, 2, 5};
      6'h00: path = {0, 1, 6, 7};
      6'h04: path = {0, 1, 8};
      6'h02: path = {0, 1, 9};
      6'h08: path = {0, 1, 10, 11};
      default: path = {0, 1};
    endcase
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic test_reset;
    sel = 1'b0;
    Opcode = 6'h2b;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    total++; if (st !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", st); end
    mem_ready = 1'b1;
    #1;
    total++; if (ctl !== exp_ctl(0, 1'b0, 1'b0)) begin bad++; $display("FAIL reset_ctl got=%h exp=%h", ctl, exp_ctl(0, 1'b0, 1'b0)); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (st !== 4'd5 || ctl[12] !== 1'b1) begin bad++; $display("FAIL sw_memwr got=%0d/%b exp=5/1", st, ctl[12]); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (st !== 4'd0 || ctl !== exp_ctl(0, 1'b0, 1'b0)) begin bad++; $display("FAIL async_reset got=%0d/%h exp=0/%h", st, ctl, exp_ctl(0, 1'b0, 1'b0)); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic test_lw;
    int exp_s[6] = '{0, 1, 2, 3, 4, 0};
    int dones = 0;
    sel = 1'b0;
    do_reset();
    Opcode = 6'h23;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++; if (st !== 4'(exp_s[i])) begin bad++; $display("FAIL lw_state step=%0d got=%0d exp=%0d", i, st, exp_s[i]); end
      total++; if (ctl[8] !== (exp_s[i] == 4) || ctl[10] !== (exp_s[i] == 4)) begin bad++; $display("FAIL lw_regwrite step=%0d got=%b%b exp=%b", i, ctl[8], ctl[10], exp_s[i] == 4); end
      if (i < 5) dones += int'(ctl[0]);
      @(posedge clk);
      #1;
    end
    total++; if (dones != 1) begin bad++; $display("FAIL lw_done_count got=%0d exp=1", dones); end
  endtask
  task automatic test_rtype;
    int exp_s[5] = '{0, 1, 6, 7, 0};
    sel = 1'b0;
    do_reset();
    Opcode = 6'h00;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (st !== 4'(exp_s[i]) || ctl !== exp_ctl(exp_s[i], 1'b1, 1'b0)) begin bad++; $display("FAIL rtype step=%0d got=%0d/%h exp=%0d/%h", i, st, ctl, exp_s[i], exp_ctl(exp_s[i], 1'b1, 1'b0)); end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_beq;
    int exp_s[4] = '{0, 1, 8, 0};
    sel = 1'b0;
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      Opcode = 6'h04;
      Zero = z[0];
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        total++; if (st !== 4'(exp_s[i]) || ctl !== exp_ctl(exp_s[i], 1'b1, 1'b0)) begin bad++; $display("FAIL beq zero=%0d step=%0d got=%0d/%h exp=%0d/%h", z, i, st, ctl, exp_s[i], exp_ctl(exp_s[i], 1'b1, 1'b0)); end
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic test_fetch_wait;
    int errs = 0;
    do_reset();
    Opcode = 6'h00;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      total++; if (s0 !== 4'd0 || c0[16] !== 1'b0 || c0[11] !== 1'b0) begin bad++; $display("FAIL wait_hold cyc=%0d got=%0d/%b%b exp=0/00", i, s0, c0[16], c0[11]); end
      total++; if (s1 !== 4'd0) begin bad++; $display("FAIL tmo_state cyc=%0d got=%0d exp=0", i, s1); end
      errs += int'(e1);
      total++; if (e0 !== 1'b0) begin bad++; $display("FAIL notmo_err cyc=%0d got=%b exp=0", i, e0); end
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    total++; if ({c0[16], c0[11], c1[16], c1[11]} !== 4'b1111) begin bad++; $display("FAIL wait_ready got=%b exp=1111", {c0[16], c0[11], c1[16], c1[11]}); end
    total++; if (errs != 1 || e1 !== 1'b0) begin bad++; $display("FAIL tmo_err_pulses got=%0d exp=1", errs + int'(e1)); end
    @(posedge clk);
    #1;
    total++; if (s0 !== 4'd1 || s1 !== 4'd1) begin bad++; $display("FAIL wait_decode got=%0d/%0d exp=1/1", s0, s1); end
  endtask
  task automatic test_ready_wins;
    sel = 1'b1;
    do_reset();
    Opcode = 6'h23;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(posedge clk);
    #1 mem_ready = 1'b1;
    @(negedge clk);
    total++; if (st !== 4'd3 || err !== 1'b0) begin bad++; $display("FAIL ready_wins got=%0d/%b exp=3/0", st, err); end
    @(posedge clk);
    #1;
    total++; if (st !== 4'd4) begin bad++; $display("FAIL ready_wins_next got=%0d exp=4", st); end
  endtask
  task automatic test_illegal;
    sel = 1'b0;
    do_reset();
    Opcode = 6'h3f;
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (st !== 4'd1 || ill !== 1'b0 || ctl !== exp_ctl(1, 1'b1, !TRAP_EN)) begin bad++; $display("FAIL illegal_decode got=%0d/%b/%h exp=1/0/%h", st, ill, ctl, exp_ctl(1, 1'b1, !TRAP_EN)); end
    @(posedge clk);
    #1;
    if (TRAP_EN) begin
      for (int i = 0; i < 12; i++) begin
        mem_ready = 1'($urandom);
        @(negedge clk);
        total++; if (st !== 4'd12 || ill !== 1'b1 || ctl !== 17'd0) begin bad++; $display("FAIL trap_hold cyc=%0d got=%0d/%b/%h exp=12/1/0", i, st, ill, ctl); end
        @(posedge clk);
        #1;
      end
    end else begin
      @(negedge clk);
      total++; if (st !== 4'd0 || ill !== 1'b0) begin bad++; $display("FAIL nop_return got=%0d/%b exp=0/0", st, ill); end
    end
  endtask
  task automatic test_random(input int tmo);
    logic [5:0] ops[6] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h08};
    sel = tmo != 0;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int idx = 0, w = 0;
      Opcode = ops[$urandom_range(0, 5)];
      Zero = 1'($urandom);
      build_path(Opcode);
      while (idx < path.size()) begin
        int s = path[idx];
        bit mem = s == 0 || s == 3 || s == 5;
        bit mr, e;
        mr = mem ? ((tmo == 0 && w >= 4) || $urandom_range(0, 4) < 3) : 1'($urandom);
        e = tmo != 0 && mem && !mr && w == tmo - 1;
        mem_ready = mr;
        @(negedge clk);
        total++; if (st !== 4'(s) || ctl !== exp_ctl(s, mr, 1'b0) || err !== e || ill !== 1'b0) begin bad++; $display("FAIL random tmo=%0d op=%h got=%0d/%h/%b/%b exp=%0d/%h/%b/0", tmo, Opcode, st, ctl, err, ill, s, exp_ctl(s, mr, 1'b0), e); end
        @(posedge clk);
        #1;
        if (e) break;
        if (mem && !mr) w++;
        else begin w = 0; idx++; end
      end
    end
  endtask
  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_fetch_wait();
    test_ready_wins();
    test_illegal();
    test_random(0);
    test_random(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Moore-style main control FSM for a multicycle MIPS datapath.
- Sequences one shared ALU, one unified instruction/data memory and the register file across FETCH/DECODE/EXECUTE/MEM/WRITEBACK steps.
- Drives the 2-bit ALUOp consumed by the ALU control decoder: 00 add, 01 sub, 10 use Funct.
- Supports R-type, lw, sw, beq, j and addi; waits on a memory-ready handshake.

Parameters:
- STATE_W, 4, width of the state register and of the state debug output.
- MEM_TIMEOUT, 0, maximum wait cycles on mem_ready. 0 means wait forever. Nonzero means abort to FETCH and pulse mem_err.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- Opcode  in  6  instruction bits [31:26] from the instruction register.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by Zero.
- IorD  out  1  memory address source: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register-file write data: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  write register: 0 = rt, 1 = rd.
- RegWrite  out  1  register-file write enable.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUOp  out  2  to the ALU control block.
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- mem_err  out  1  one-cycle pulse on memory timeout.
- illegal_op  out  1  unsupported-opcode indication (see Optional Feature).
- state  out  STATE_W  current state, for debug.

Behaviour:
- State register is reset asynchronously to FETCH (0) when rst_n = 0. Outputs are decoded combinationally from state only (Moore), except where noted.
- Outputs with no value listed in a state are 0. Outputs during reset equal the FETCH decode: MemRead = 1, ALUSrcB = 01, all others 0.
- Reset asserted mid-instruction abandons the instruction; no write is asserted after rst_n falls.
- FETCH (0):
  - Drives MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite = mem_ready and PCWrite = mem_ready (Mealy-gated).
  - Moves to DECODE when mem_ready = 1, otherwise stays.
- DECODE (1): ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target into ALUOut). Next state by Opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EX
  - other -> see Optional Feature
- MEMADR (2): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD (3): MemRead = 1, IorD = 1. Moves to MEMWB when mem_ready = 1.
- MEMWB (4): RegWrite = 1, MemtoReg = 1, RegDst = 0, instr_done = 1. Next is FETCH.
- MEMWR (5): MemWrite = 1, IorD = 1, instr_done = mem_ready. Moves to FETCH when mem_ready = 1.
- EXEC (6): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next is RWB.
- RWB (7): RegWrite = 1, RegDst = 1, MemtoReg = 0, instr_done = 1. Next is FETCH.
- BRANCH (8): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01, instr_done = 1. Next is FETCH.
- JUMP (9): PCWrite = 1, PCSource = 10, instr_done = 1. Next is FETCH.
- ADDI_EX (10): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next is ADDI_WB.
- ADDI_WB (11): RegWrite = 1, RegDst = 0, MemtoReg = 0, instr_done = 1. Next is FETCH.
- Unused encodings (12..15): all outputs 0, next state FETCH.
- Memory timeout, when MEM_TIMEOUT > 0:
  - A wait counter clears on entry to FETCH, MEMRD or MEMWR and increments on each cycle with mem_ready = 0.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0, the FSM forces FETCH and mem_err pulses for 1 cycle.
  - mem_ready = 1 on the timeout cycle wins: the access completes normally and mem_err stays 0.
- Latencies, with mem_ready = 1 and no wait states:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - addi: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles

Optional Feature:
- Macro: MIPS_ILLEGAL_TRAP_EN.
- Defined:
  - An unsupported Opcode in DECODE moves to TRAP (12), where all enables are 0.
  - The FSM holds in TRAP until reset.
  - illegal_op = 1 while in TRAP and is cleared only by rst_n.
- Undefined:
  - An unsupported Opcode is treated as a NOP: DECODE -> FETCH, with instr_done = 1 in DECODE.
  - illegal_op is tied to 0.
  - State 12 is an unused encoding.

Test Plan:
- Reset with rst_n = 0 mid-MEMWR -> state = 0 immediately (asynchronously); MemWrite = 0, MemRead = 1, ALUSrcB = 01.
- lw (Opcode 100011), mem_ready = 1 throughout -> states 0,1,2,3,4,0; RegWrite and MemtoReg = 1 only in state 4; exactly one instr_done pulse.
- R-type (000000) -> EXEC shows ALUOp = 10 and ALUSrcB = 00; RWB shows RegDst = 1 and RegWrite = 1; 4 cycles total.
- beq (000100) with Zero = 1 and with Zero = 0 -> BRANCH shows ALUOp = 01, PCWriteCond = 1, PCSource = 01 in both runs; back to FETCH after 3 cycles.
- FETCH with mem_ready low for 3 cycles, MEM_TIMEOUT = 0 -> FSM holds with IRWrite = 0 and PCWrite = 0 for 3 cycles, then IRWrite = 1 and PCWrite = 1 on the ready cycle. Repeat with MEM_TIMEOUT = 2 -> mem_err pulses once and state stays FETCH.
- Opcode 111111 -> with MIPS_ILLEGAL_TRAP_EN: state = 12 and illegal_op = 1, held for 10+ cycles. Without the macro: DECODE -> FETCH with instr_done = 1 and illegal_op = 0.
